rgb_pwm_ctrl: RTL and testbench



---
 rtl/rgb_pwm_ctrl_pkg.sv | 18 +
 rtl/pwm_envelope.sv | 62 ++++++
 rtl/rgb_pwm_ctrl.sv | 146 ++++++++++++++
 tb/tb_rgb_pwm_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_ctrl_pkg.sv
// Shared register map, CTRL bit positions and envelope direction type for rgb_pwm_ctrl.
package rgb_pwm_ctrl_pkg;

    localparam logic [3:0] ADDR_DUTY0 = 4'h0;
    localparam logic [3:0] ADDR_ENV   = 4'hE;
    localparam logic [3:0] ADDR_CTRL  = 4'hF;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_BREATHE = 1;
    localparam int unsigned CTRL_INV     = 2;
    localparam int unsigned CTRL_W       = 3;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } env_dir_e;

endpackage

// File: rtl/pwm_envelope.sv
// Triangle "breathe" envelope: steps once per PWM period, bouncing between 0 and all-ones.
module pwm_envelope
    import rgb_pwm_ctrl_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wrap,
    input  logic                run,
    output logic [PWM_BITS-1:0] env
);

    localparam logic [PWM_BITS-1:0] ENV_MAX = '1;
    localparam logic [PWM_BITS-1:0] ENV_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] env_q, env_d;
    env_dir_e            dir_q, dir_d;

    // Next envelope value: bounce at the ends on the same wrap, clear when not breathing.
    always_comb begin
        env_d = env_q;
        dir_d = dir_q;
        if (!run) begin
            env_d = '0;
            dir_d = DirUp;
        end else if (wrap) begin
            unique case (dir_q)
                DirUp: begin
                    if (env_q == ENV_MAX) begin
                        dir_d = DirDown;
                        env_d = env_q - ENV_ONE;
                    end else begin
                        env_d = env_q + ENV_ONE;
                    end
                end
                DirDown: begin
                    if (env_q == '0) begin
                        dir_d = DirUp;
                        env_d = env_q + ENV_ONE;
                    end else begin
                        env_d = env_q - ENV_ONE;
                    end
                end
            endcase
        end
    end

    // Envelope state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            env_q <= '0;
            dir_q <= DirUp;
        end else begin
            env_q <= env_d;
            dir_q <= dir_d;
        end
    end

    assign env = env_q;

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Bus-programmable multi-channel PWM LED controller with double-buffered duties,
// global enable/invert and an optional breathe envelope scaling every duty.
module rgb_pwm_ctrl
    import rgb_pwm_ctrl_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESCALE = 47
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                we,
    input  logic [3:0]          addr,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    output logic [CHANNELS-1:0] pwm_o
);

    localparam int unsigned         PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);
    localparam int unsigned         PROD_W   = 2 * PWM_BITS;

    logic [PWM_BITS-1:0] duty_q   [CHANNELS];
    logic [PWM_BITS-1:0] shadow_q [CHANNELS];
    logic [PWM_BITS-1:0] eff      [CHANNELS];
    logic [CTRL_W-1:0]   ctrl_q;
    logic [PRE_W-1:0]    pre_q;
    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] env;
    logic [CHANNELS-1:0] raw;
    logic [7:0]          rd_data;
    logic                en, breathe, inv, tick, wrap;
    logic                unused_din;

    assign en         = ctrl_q[CTRL_EN];
    assign breathe    = ctrl_q[CTRL_BREATHE];
    assign inv        = ctrl_q[CTRL_INV];
    assign unused_din = ^din;

    // Register file writes; unmapped and read-only addresses are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) duty_q[i] <= '0;
            ctrl_q <= '0;
        end else if (cs && we) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (addr == ADDR_DUTY0 + 4'(i)) duty_q[i] <= din[PWM_BITS-1:0];
            end
            if (addr == ADDR_CTRL) ctrl_q <= din[CTRL_W-1:0];
        end
    end

    // Read data mux; anything unmapped reads as zero.
    always_comb begin
        rd_data = '0;
        if (addr == ADDR_CTRL) begin
            rd_data = 8'(ctrl_q);
        end else if (addr == ADDR_ENV) begin
            rd_data = 8'(env);
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (addr == ADDR_DUTY0 + 4'(i)) rd_data = 8'(duty_q[i]);
            end
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (cs && !we) begin
            dout <= rd_data;
        end
    end

    // With PRESCALE = 1 the prescaler stays at 0 and tick is permanently high.
    assign tick = (pre_q == PRE_LAST);
    assign wrap = en && tick && (cnt_q == CNT_LAST);

    // Prescaler and PWM counter, parked at zero while disabled so a new enable starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (!en) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PRE_ONE;
            if (tick) cnt_q <= cnt_q + CNT_ONE;
        end
    end

    pwm_envelope #(
        .PWM_BITS (PWM_BITS)
    ) u_envelope (
        .clk   (clk),
        .reset (reset),
        .wrap  (wrap),
        .run   (en && breathe),
        .env   (env)
    );

    // Effective duty: raw DUTY, or DUTY scaled by the envelope (upper half of the product).
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            eff[i] = duty_q[i];
            if (breathe) begin
                eff[i] = PWM_BITS'((PROD_W'(duty_q[i]) * PROD_W'(env)) >> PWM_BITS);
            end
        end
    end

    // Shadow duties only change on wrap, so a period never sees a half-applied update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
        end else if (!en) begin
            for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
        end else if (wrap) begin
            for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= eff[i];
        end
    end

    // Per-channel compare against the live counter.
    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = en && (cnt_q < shadow_q[i]);
        end
    end

    // Registered outputs with global polarity inversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_o <= '0;
        end else begin
            pwm_o <= raw ^ {CHANNELS{inv}};
        end
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Scoreboard bench for rgb_pwm_ctrl (CHANNELS=3, PWM_BITS=4, PRESCALE=2, 32-clk period).
module tb_rgb_pwm_ctrl;

    localparam int CH = 3;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          cs    = 1'b0;
    logic          we    = 1'b0;
    logic [3:0]    addr  = 4'h0;
    logic [7:0]    din   = 8'h00;
    logic [7:0]    dout;
    logic [CH-1:0] pwm_o;

    rgb_pwm_ctrl #(
        .CHANNELS (3),
        .PWM_BITS (4),
        .PRESCALE (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .pwm_o (pwm_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;   // number of rising edges seen so far
    int win_base = 32'h7fff_ffff;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_exp_t;

    typedef struct {
        string name;
        int    e0;
        int    e1;
        int    e2;
    } per_exp_t;

    rd_exp_t  rd_q[$];
    per_exp_t per_q[$];
    logic     rd_p1 = 1'b0;
    logic     rd_p2 = 1'b0;
    int       acc[CH];

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Expected envelope value after k wraps of breathing.
    function automatic int env_at(input int k);
        if (k <= 15) return k;
        else if (k <= 30) return 30 - k;
        else return k - 30;
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rd_p1 <= cs && !we;
        rd_p2 <= rd_p1;
    end

    // Monitor: read data two edges after a read strobe; PWM high-time per 32-clk window.
    always @(negedge clk) begin
        if (rd_p2) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected read: dout %0d with nothing expected", dout);
            end else begin
                rd_exp_t r;
                r = rd_q.pop_front();
                chk(r.name, int'(dout), int'(r.exp));
            end
        end
        if (per_q.size() > 0 && cyc >= win_base) begin
            int ph;
            ph = (cyc - win_base) % 32;
            for (int i = 0; i < CH; i++) begin
                acc[i] = (ph == 0) ? int'(pwm_o[i]) : acc[i] + int'(pwm_o[i]);
            end
            if (ph == 31) begin
                per_exp_t p;
                p = per_q.pop_front();
                chk({p.name, " ch0 high clks"}, acc[0], p.e0);
                chk({p.name, " ch1 high clks"}, acc[1], p.e1);
                chk({p.name, " ch2 high clks"}, acc[2], p.e2);
            end
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [7:0] e, input string nm);
        rd_exp_t r;
        r.name = nm;
        r.exp  = e;
        rd_q.push_back(r);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic push_per(input string nm, input int e0, input int e1, input int e2);
        per_exp_t p;
        p.name = nm; p.e0 = e0; p.e1 = e1; p.e2 = e2;
        per_q.push_back(p);
    endtask

    // Returns at the falling edge just before rising edge e, so a bus op lands on edge e.
    task automatic wait_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
        if (cyc != e - 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL schedule: at edge %0d, wanted %0d", cyc, e - 1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((rd_q.size() > 0 || per_q.size() > 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (rd_q.size() > 0 || per_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain timeout: %0d reads and %0d periods pending, expected 0",
                     rd_q.size(), per_q.size());
            rd_q.delete();
            per_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset pwm_o", int'(pwm_o), 0);
        chk("reset dout", int'(dout), 0);
        reset = 1'b0;
        @(negedge clk);
        bus_rd(4'hF, 8'h00, "CTRL after reset");
        bus_rd(4'h0, 8'h00, "DUTY0 after reset");
        bus_rd(4'h2, 8'h00, "DUTY2 after reset");
        bus_rd(4'hE, 8'h00, "ENV after reset");

        // Bus decode
        bus_wr(4'hF, 8'hFF);
        bus_rd(4'hF, 8'h07, "CTRL reserved bits");
        bus_wr(4'hF, 8'h00);
        bus_rd(4'h7, 8'h00, "unmapped 0x7");
        bus_rd(4'h3, 8'h00, "unmapped 0x3");
        bus_wr(4'h5, 8'hAB);
        bus_rd(4'h5, 8'h00, "write to 0x5 ignored");
        bus_rd(4'h1, 8'h00, "DUTY1 untouched by 0x5");
        bus_wr(4'h0, 8'h3C);
        bus_rd(4'h0, 8'h0C, "DUTY0 keeps low bits");
        bus_wr(4'hE, 8'h55);
        bus_rd(4'hE, 8'h00, "ENV read-only");

        // Duties and double-buffered updates
        bus_wr(4'h0, 8'd4);
        bus_wr(4'h1, 8'd0);
        bus_wr(4'h2, 8'd15);
        bus_rd(4'h2, 8'h0F, "DUTY2 readback");
        n = cyc + 1;
        win_base = n + 1;
        push_per("duty first period", 0, 0, 0);
        push_per("duty period 1", 8, 0, 30);
        push_per("duty period 2", 8, 0, 30);
        push_per("mid-period write, old", 8, 0, 30);
        push_per("mid-period write, new", 20, 0, 30);
        push_per("wrap write, old", 20, 0, 30);
        push_per("wrap write, new", 4, 0, 30);
        bus_wr(4'hF, 8'h01);
        wait_edge(n + 50);
        bus_rd(4'hE, 8'h00, "ENV idle without breathe");
        wait_edge(n + 110);
        bus_wr(4'h0, 8'd10);
        wait_edge(n + 160);
        bus_wr(4'h0, 8'd2);
        wait_drain(400);

        // Invert while running
        bus_wr(4'hF, 8'h00);
        bus_wr(4'h0, 8'd4);
        n = cyc + 1;
        win_base = n + 1;
        push_per("invert first period", 32, 32, 32);
        push_per("invert steady", 24, 32, 2);
        bus_wr(4'hF, 8'h05);
        wait_drain(200);

        // Disabled with invert, then clean re-enable
        n = cyc + 1;
        win_base = n + 1;
        push_per("disabled inverted", 32, 32, 32);
        push_per("disabled inverted 2", 32, 32, 32);
        bus_wr(4'hF, 8'h04);
        wait_drain(200);
        repeat (7) @(negedge clk);
        n = cyc + 1;
        win_base = n + 1;
        push_per("re-enable first period", 0, 0, 0);
        push_per("re-enable steady", 8, 0, 30);
        bus_wr(4'hF, 8'h01);
        wait_drain(200);

        // Breathe envelope
        bus_wr(4'hF, 8'h00);
        bus_wr(4'h0, 8'd15);
        bus_wr(4'h1, 8'd4);
        n = cyc + 1;
        win_base = n + 1;
        for (int m = 0; m < 32; m++) begin
            e = (m == 0) ? 0 : env_at(m - 1);
            push_per($sformatf("breathe period %0d", m),
                     2 * ((15 * e) >> 4), 2 * ((4 * e) >> 4), 2 * ((15 * e) >> 4));
        end
        bus_wr(4'hF, 8'h03);
        bus_rd(4'hF, 8'h03, "CTRL breathe readback");
        for (int k = 1; k <= 31; k++) begin
            wait_edge(n + 32 * k + 16);
            bus_rd(4'hE, 8'(env_at(k)), $sformatf("ENV after wrap %0d", k));
        end
        wait_drain(200);

        // Asynchronous reset in the middle of a period
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid-run reset pwm_o", int'(pwm_o), 0);
        chk("mid-run reset dout", int'(dout), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_rd(4'hF, 8'h00, "CTRL after mid-run reset");
        bus_rd(4'h0, 8'h00, "DUTY0 after mid-run reset");
        bus_rd(4'h2, 8'h00, "DUTY2 after mid-run reset");
        bus_rd(4'hE, 8'h00, "ENV after mid-run reset");
        chk("pwm_o after mid-run reset", int'(pwm_o), 0);
        wait_drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
